// File: rtl/timer_countdown.sv
// Prescaled countdown timer: latches a parameter index, loads its duration from an
// external parameter bank, and counts it down in ticks of DIV clock cycles.
//
// state  | meaning
// IDLE   | waiting for start_timer
// LOAD   | one cycle: capture value from the bank, clear prescaler
// COUNT  | prescaler running, remaining decrements on each tick
// EXPIRE | one cycle: expired pulse, remaining held at 0
module timer_countdown #(
    parameter int DIV = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval_sel,
    input  logic [4:0] value,
    output logic [1:0] interval,
    output logic [4:0] remaining,
    output logic       one_hz_enable,
    output logic       busy,
    output logic       expired
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, EXPIRE} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            interval      <= 2'b00;
            remaining     <= 5'd0;
            prescaler     <= '0;
            one_hz_enable <= 1'b0;
            busy          <= 1'b0;
            expired       <= 1'b0;
        end else begin
            one_hz_enable <= 1'b0;
            expired       <= 1'b0;
            // A start request wins in every state, including a terminal tick.
            if (start_timer) begin
                state     <= LOAD;
                interval  <= interval_sel;
                prescaler <= '0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        remaining <= value;
                        prescaler <= '0;
                        if (value != 5'd0) begin
                            state <= COUNT;
                            busy  <= 1'b1;
                        end else begin
                            state   <= EXPIRE;
                            busy    <= 1'b0;
                            expired <= 1'b1;
                        end
                    end
                    COUNT: begin
                        if (prescaler == PS_LAST) begin
                            prescaler <= '0;
                            if (remaining != 5'd0)
                                remaining <= remaining - 5'd1;
                            if (remaining <= 5'd1) begin
                                state   <= EXPIRE;
                                busy    <= 1'b0;
                                expired <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                            // Registered so the pulse lines up with the decrementing cycle.
                            one_hz_enable <= (prescaler == PS_LAST - 1'b1);
                        end
                    end
                    EXPIRE: begin
                        state     <= IDLE;
                        remaining <= 5'd0;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_countdown.sv
// Directed bench for timer_countdown (DIV=4) with a cycle-stamped scoreboard of
// expected tick and expiry cycles, checked by a negedge monitor.
module tb_timer_countdown;

    localparam int DIV = 4;

    logic       clock;
    logic       reset;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic [4:0] value;
    logic [1:0] interval;
    logic [4:0] remaining;
    logic       one_hz_enable;
    logic       busy;
    logic       expired;

    logic [4:0] bank [4];
    int cyc;
    int errors;
    int checks;
    int tick_q[$];
    int exp_q[$];
    int mon_e;

    timer_countdown #(.DIV(DIV)) dut (
        .clock(clock),
        .reset(reset),
        .start_timer(start_timer),
        .interval_sel(interval_sel),
        .value(value),
        .interval(interval),
        .remaining(remaining),
        .one_hz_enable(one_hz_enable),
        .busy(busy),
        .expired(expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    assign value = bank[interval];

    always @(negedge clock) begin
        if (one_hz_enable === 1'b1) begin
            mon_e = (tick_q.size() > 0) ? tick_q.pop_front() : -1;
            checks++;
            assert (cyc === mon_e) else begin
                errors++;
                $error("FAIL tick_cycle observed=%0d expected=%0d", cyc, mon_e);
            end
        end
        if (expired === 1'b1) begin
            mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++;
            assert (cyc === mon_e) else begin
                errors++;
                $error("FAIL expired_cycle observed=%0d expected=%0d", cyc, mon_e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic prune(input int limit);
        while (tick_q.size() > 0 && tick_q[tick_q.size()-1] > limit) void'(tick_q.pop_back());
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1] > limit) void'(exp_q.pop_back());
    endtask

    // Drives a start request, predicts its tick/expiry cycles, and lands in the LOAD cycle.
    task automatic do_start(input logic [1:0] sel);
        int k;
        int v;
        prune(cyc);
        k = cyc + 1;
        v = int'(bank[sel]);
        for (int j = 1; j <= v; j++) tick_q.push_back(k + j * DIV);
        exp_q.push_back(k + 1 + v * DIV);
        start_timer  = 1'b1;
        interval_sel = sel;
        step();
        start_timer  = 1'b0;
    endtask

    task automatic wait_rem(input int target, input int budget);
        int n = 0;
        while (int'(remaining) != target && n < budget) begin
            step();
            n++;
        end
        chk("wait_remaining", int'(remaining), target);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((tick_q.size() + exp_q.size()) != 0 && n < budget) begin
            step();
            n++;
        end
        chk("scoreboard_drain", tick_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        errors = 0;
        checks = 0;
        bank[0] = 5'd0;
        bank[1] = 5'd5;
        bank[2] = 5'd7;
        bank[3] = 5'd3;
        reset        = 1'b1;
        start_timer  = 1'b0;
        interval_sel = 2'b00;
        step();
        step();
        reset = 1'b0;

        chk("rst_interval", int'(interval), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_flags", int'({busy, expired, one_hz_enable}), 0);

        // Basic countdown, index 01 -> 5 ticks, expiry 21 cycles after start.
        do_start(2'b01);
        chk("a_interval", int'(interval), 1);
        chk("a_busy_load", int'(busy), 1);
        step();
        chk("a_remaining_loaded", int'(remaining), 5);
        chk("a_no_tick_first", int'(one_hz_enable), 0);
        wait_done(60);
        chk("a_busy_after", int'(busy), 0);
        chk("a_remaining_after", int'(remaining), 0);

        // Zero duration expires right after LOAD with no tick.
        do_start(2'b00);
        chk("b_busy_load", int'(busy), 1);
        step();
        chk("b_expired", int'(expired), 1);
        chk("b_busy_expire", int'(busy), 0);
        wait_done(10);

        // Restart mid-count with a different index.
        do_start(2'b01);
        wait_rem(2, 40);
        do_start(2'b11);
        chk("c_interval", int'(interval), 3);
        step();
        chk("c_remaining_reload", int'(remaining), 3);
        wait_done(40);

        // Reset mid-count aborts, start accepted right after.
        do_start(2'b01);
        wait_rem(3, 40);
        reset = 1'b1;
        prune(cyc);
        step();
        reset = 1'b0;
        chk("d_interval", int'(interval), 0);
        chk("d_remaining", int'(remaining), 0);
        chk("d_flags", int'({busy, expired, one_hz_enable}), 0);
        do_start(2'b01);
        chk("d_interval_restart", int'(interval), 1);
        step();
        chk("d_remaining_restart", int'(remaining), 5);
        wait_done(60);

        // Bank reprogrammed and interval_sel wiggled mid-count: both ignored.
        do_start(2'b01);
        repeat (6) step();
        bank[1] = 5'd9;
        interval_sel = 2'b10;
        step();
        chk("e_interval_hold", int'(interval), 1);
        wait_done(60);
        chk("e_remaining_end", int'(remaining), 0);
        bank[1] = 5'd5;

        // Start coincident with the terminal tick: no expiry, new countdown runs.
        do_start(2'b11);
        n = 0;
        while (!(one_hz_enable === 1'b1 && remaining == 5'd1) && n < 40) begin
            step();
            n++;
        end
        chk("f_terminal_tick_seen", int'(remaining), 1);
        do_start(2'b01);
        chk("f_busy_load", int'(busy), 1);
        chk("f_no_expired", int'(expired), 0);
        chk("f_remaining_held", int'(remaining), 1);
        step();
        chk("f_remaining_reload", int'(remaining), 5);
        wait_done(60);
        chk("f_busy_after", int'(busy), 0);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
